// File: rtl/imem_loader.sv
// Streams a little-endian byte image into instruction memory, one 32-bit word at a time,
// holding the CPU in reset until the trailing XOR checksum byte has been checked.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  load_ok,
  output logic                  load_err
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [1:0]            byte_idx_reg, byte_idx_next;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic [7:0]            csum_reg, csum_next;
  logic [31:0]           word_reg, word_next;
  logic                  load_ok_reg, load_ok_next;
  logic                  load_err_reg, load_err_next;
  logic                  byte_take;

  assign byte_take = (state_reg == RECV) && in_valid;

  // Each byte lane captures in_data only when byte_idx points at it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_next[8*gi +: 8] = (byte_take && (byte_idx_reg == 2'(gi)))
                                  ? in_data : word_reg[8*gi +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      byte_idx_reg <= '0;
      count_reg    <= '0;
      csum_reg     <= '0;
      word_reg     <= '0;
      load_ok_reg  <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      byte_idx_reg <= byte_idx_next;
      count_reg    <= count_next;
      csum_reg     <= csum_next;
      word_reg     <= word_next;
      load_ok_reg  <= load_ok_next;
      load_err_reg <= load_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    byte_idx_next = byte_idx_reg;
    count_next    = count_reg;
    csum_next     = csum_reg;
    load_ok_next  = load_ok_reg;
    load_err_next = load_err_reg;
    in_ready      = 1'b0;
    mem_we        = 1'b0;
    cpu_hold      = 1'b0;
    done          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          load_ok_next  = 1'b0;
          load_err_next = 1'b0;
          if (num_words != '0) begin
            count_next    = num_words;
            addr_next     = ADDR_WIDTH'(BASE_ADDR);
            byte_idx_next = '0;
            csum_next     = '0;
            state_next    = RECV;
          end else begin
            // An empty image is trivially valid.
            load_ok_next = 1'b1;
            state_next   = DONE;
          end
        end
      end
      RECV: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) begin
          csum_next     = csum_reg ^ in_data;
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) state_next = WRITE;
        end
      end
      WRITE: begin
        mem_we     = 1'b1;
        cpu_hold   = 1'b1;
        addr_next  = addr_reg + ADDR_WIDTH'(4);
        count_next = count_reg - 1'b1;
        state_next = (count_reg == CNT_WIDTH'(1)) ? CHECK : RECV;
      end
      CHECK: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) begin
          load_ok_next  = (in_data == csum_reg);
          load_err_next = (in_data != csum_reg);
          state_next    = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        cpu_hold   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = word_reg;
  assign load_ok   = load_ok_reg;
  assign load_err  = load_err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: unit 0 uses the default map, unit 1 a 16-byte map
// based at 12 so the address wraps. A monitor pops expected writes/results as the DUT emits them.
module tb_imem_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic ok;
    logic err;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  start_v;
  logic [7:0]  num_words_a [2];
  logic [1:0]  in_valid_v;
  logic [7:0]  in_data_a [2];
  logic [1:0]  in_ready_v, mem_we_v, cpu_hold_v, done_v, ok_v, err_v;
  logic [7:0]  ma0;
  logic [3:0]  ma1;
  logic [31:0] wd0, wd1;

  wr_t  exp_wr_q  [2][$];
  res_t exp_res_q [2][$];
  res_t last_res  [2];
  logic [1:0] after_done;
  logic [7:0] byte_src [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0), .CNT_WIDTH(8)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .num_words(num_words_a[0]),
    .in_valid(in_valid_v[0]), .in_data(in_data_a[0]), .in_ready(in_ready_v[0]),
    .mem_we(mem_we_v[0]), .mem_addr(ma0), .mem_wdata(wd0), .cpu_hold(cpu_hold_v[0]),
    .done(done_v[0]), .load_ok(ok_v[0]), .load_err(err_v[0])
  );

  imem_loader #(.ADDR_WIDTH(4), .BASE_ADDR(12), .CNT_WIDTH(8)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .num_words(num_words_a[1]),
    .in_valid(in_valid_v[1]), .in_data(in_data_a[1]), .in_ready(in_ready_v[1]),
    .mem_we(mem_we_v[1]), .mem_addr(ma1), .mem_wdata(wd1), .cpu_hold(cpu_hold_v[1]),
    .done(done_v[1]), .load_ok(ok_v[1]), .load_err(err_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done.
  always @(negedge clk) begin
    logic [7:0]  a;
    logic [31:0] d;
    wr_t  w;
    res_t r;
    if (reset) begin
      after_done = 2'b00;
    end else begin
      for (int u = 0; u < 2; u++) begin
        a = (u == 0) ? ma0 : {4'h0, ma1};
        d = (u == 0) ? wd0 : wd1;
        if (ok_v[u] && err_v[u]) chk("ok_err_exclusive", 1, 0);
        if (after_done[u]) begin
          chk("hold_drops_after_done", cpu_hold_v[u], 0);
          chk("done_single_pulse", done_v[u], 0);
          chk("ok_sticky", ok_v[u], last_res[u].ok);
          chk("err_sticky", err_v[u], last_res[u].err);
          after_done[u] = 1'b0;
        end
        if (mem_we_v[u]) begin
          chk("ready_low_in_write", in_ready_v[u], 0);
          chk("hold_in_write", cpu_hold_v[u], 1);
          if (exp_wr_q[u].size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            w = exp_wr_q[u].pop_front();
            chk("write_addr", a, w.addr);
            chk("write_data", d, w.data);
            $display("unit%0d write addr=%h data=%h", u, a, d);
          end
        end
        if (done_v[u]) begin
          chk("hold_in_done", cpu_hold_v[u], 1);
          if (exp_res_q[u].size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            r = exp_res_q[u].pop_front();
            chk("load_ok", ok_v[u], r.ok);
            chk("load_err", err_v[u], r.err);
            last_res[u] = r;
            after_done[u] = 1'b1;
            $display("unit%0d done ok=%0b err=%0b", u, ok_v[u], err_v[u]);
          end
        end
      end
    end
  end

  task automatic send_byte(input int u, input logic [7:0] b, input int max_gap);
    int g, n;
    g = $urandom_range(max_gap, 0);
    repeat (g) @(negedge clk);
    @(negedge clk);
    in_valid_v[u] = 1'b1;
    in_data_a[u]  = b;
    n = 0;
    while (!in_ready_v[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid_v[u] = 1'b0;
  endtask

  // Reference model: words from bytes (first byte = LSB), addresses base+4i modulo the
  // map size, checksum = XOR of every image byte.
  task automatic run_load(input int u, input int n, input int max_gap, input bit bad,
                          input bit poke_start);
    logic [7:0] img [$];
    logic [7:0] csum, sent, b;
    logic [31:0] word;
    int base, mask, t;
    base = (u == 0) ? 0 : 12;
    mask = (u == 0) ? 8'hFF : 8'h0F;
    csum = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = (byte_src.size() != 0) ? byte_src.pop_front() : 8'($urandom);
      img.push_back(b);
      csum ^= b;
    end
    for (int i = 0; i < n; i++) begin
      word = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
      exp_wr_q[u].push_back('{addr: 8'((base + 4 * i) & mask), data: word});
    end
    if (byte_src.size() != 0) sent = byte_src.pop_front();
    else if (bad) sent = csum ^ 8'($urandom_range(255, 1));
    else sent = csum;
    exp_res_q[u].push_back('{ok: (sent == csum), err: (sent != csum)});

    @(negedge clk);
    start_v[u]     = 1'b1;
    num_words_a[u] = 8'(n);
    @(negedge clk);
    start_v[u]     = 1'b0;
    if (n == 0) chk("zero_done_next_cycle", done_v[u], 1);
    for (int i = 0; i < 4 * n; i++) begin
      send_byte(u, img[i], max_gap);
      if (poke_start && i == 1) begin
        @(negedge clk);
        start_v[u] = 1'b1;
        num_words_a[u] = 8'd7;
        @(negedge clk);
        start_v[u] = 1'b0;
      end
    end
    if (n != 0) send_byte(u, sent, max_gap);
    t = 0;
    while (!done_v[u] && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start_v = 2'b00;
    in_valid_v = 2'b00;
    for (int u = 0; u < 2; u++) begin
      num_words_a[u] = 8'h00;
      in_data_a[u] = 8'h00;
    end
    after_done = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready_v, 0);
    chk("reset_cpu_hold", cpu_hold_v, 0);
    chk("reset_mem_we", mem_we_v, 0);
    chk("reset_done", done_v, 0);
    chk("reset_ok_err", {ok_v, err_v}, 0);
    chk("reset_addr", ma0, 0);
    chk("reset_wdata", wd0, 0);
    reset = 1'b0;

    // Single word 0x00000004, checksum 04.
    byte_src = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h04};
    run_load(0, 1, 0, 0, 0);

    // Reset mid-RECV after two bytes: nothing written, flags cleared.
    @(negedge clk);
    start_v[0] = 1'b1;
    num_words_a[0] = 8'd2;
    @(negedge clk);
    start_v[0] = 1'b0;
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_in_ready", in_ready_v[0], 0);
    chk("midreset_cpu_hold", cpu_hold_v[0], 0);
    chk("midreset_ok", ok_v[0], 0);
    @(negedge clk);
    reset = 1'b0;

    // Three words with in_valid gaps and a stray start mid-load.
    run_load(0, 3, 1, 0, 1);

    // Wrong checksum: expected 5A, sent A5.
    byte_src = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'hA5};
    run_load(0, 1, 0, 1, 0);

    // Empty image.
    run_load(0, 0, 0, 0, 0);

    // Small map: second write wraps from 12 to 0.
    run_load(1, 2, 1, 0, 0);

    repeat (6) begin
      run_load($urandom_range(1, 0), $urandom_range(5, 1), 2, $urandom_range(1, 0), 0);
    end

    repeat (4) @(negedge clk);
    chk("wr_q_empty_0", exp_wr_q[0].size(), 0);
    chk("wr_q_empty_1", exp_wr_q[1].size(), 0);
    chk("res_q_empty_0", exp_res_q[0].size(), 0);
    chk("res_q_empty_1", exp_res_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
